// File: rtl/float_mul_normal_pipe.sv
// Normalise-and-round stage for the float multiplier: leading-one detect, then
// shift, round-to-nearest-even and saturate, as a 2-stage valid/ready pipeline.
module float_mul_normal_pipe #(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ins,
    input  logic [E+1:0]     ine,
    input  logic [2*M+1:0]   inm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             outs,
    output logic [E-1:0]     oute,
    output logic [M-1:0]     outm,
    output logic             ovf,
    output logic             unf,
    output logic             inexact
);

    localparam int P   = 2 * M + 2;
    localparam int LZW = $clog2(P);
    // Extra headroom so ine+1 and ine-lz (plus round carry) never wrap.
    localparam int EXW = E + 4;

    localparam logic signed [EXW-1:0] EX_ONE  = {{(EXW-1){1'b0}}, 1'b1};
    localparam logic signed [EXW-1:0] EX_ZERO = {EXW{1'b0}};
    localparam logic signed [EXW-1:0] EX_MAX  = {{(EXW-E){1'b0}}, {E{1'b1}}};

    function automatic logic [LZW-1:0] lzc(input logic [P-2:0] x);
        logic [LZW-1:0] cnt;
        logic           found;
        cnt   = {LZW{1'b0}};
        found = 1'b0;
        for (int i = P - 2; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + {{(LZW-1){1'b0}}, 1'b1};
                end
            end else begin
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    logic             v1_r, v2_r;
    logic             s1_r, rsh1_r, zero1_r;
    logic [E+1:0]     e1_r;
    logic [P-1:0]     m1_r;
    logic [LZW-1:0]   lz1_r;
    logic             en1_s, en2_s;

    assign en2_s     = !v2_r | out_ready;
    assign en1_s     = !v1_r | en2_s;
    assign in_ready  = en1_s & rst_n;
    assign out_valid = v2_r;

    // Stage 1: capture the beat with its leading-one information.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            s1_r    <= 1'b0;
            e1_r    <= {(E+2){1'b0}};
            m1_r    <= {P{1'b0}};
            rsh1_r  <= 1'b0;
            lz1_r   <= {LZW{1'b0}};
            zero1_r <= 1'b0;
        end else if (en1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_r    <= ins;
                e1_r    <= ine;
                m1_r    <= inm;
                rsh1_r  <= inm[P-1];
                lz1_r   <= lzc(inm[P-2:0]);
                zero1_r <= (inm == {P{1'b0}});
            end
        end
    end

    logic [P-1:0]            n_s;
    logic                    sh_bit_s;
    logic signed [EXW-1:0]   e1x_s, ex_s, exr_s;
    logic [M-1:0]            frac_s;
    logic                    g_s, st_s, up_s;
    logic [M:0]              fsum_s;
    logic [E-1:0]            oute_s;
    logic [M-1:0]            outm_s;
    logic                    ovf_s, unf_s, inexact_s;
    logic                    unused_s;

    assign e1x_s    = {{2{e1_r[E+1]}}, e1_r};
    assign unused_s = ^n_s[P-1:2*M];

    // Stage 2 datapath: normalise, round to nearest even, saturate.
    always_comb begin
        n_s       = {P{1'b0}};
        sh_bit_s  = 1'b0;
        ex_s      = EX_ZERO;
        exr_s     = EX_ZERO;
        oute_s    = {E{1'b0}};
        outm_s    = {M{1'b0}};
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        inexact_s = 1'b0;
        if (rsh1_r) begin
            n_s      = m1_r >> 1;
            sh_bit_s = m1_r[0];
            ex_s     = e1x_s + EX_ONE;
        end else begin
            n_s  = m1_r << lz1_r;
            ex_s = e1x_s - $signed({{(EXW-LZW){1'b0}}, lz1_r});
        end
        frac_s = n_s[2*M-1:M];
        g_s    = n_s[M-1];
        st_s   = (|n_s[M-2:0]) | sh_bit_s;
        up_s   = g_s & (st_s | frac_s[0]);
        fsum_s = {1'b0, frac_s} + {{M{1'b0}}, up_s};
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        if (fsum_s[M]) begin
            exr_s = ex_s + EX_ONE;
        end else begin
            exr_s = ex_s;
        end
        if (zero1_r) begin
            oute_s    = {E{1'b0}};
            outm_s    = {M{1'b0}};
            inexact_s = 1'b0;
        end else if (exr_s >= EX_MAX) begin
            ovf_s     = 1'b1;
            oute_s    = {E{1'b1}};
            outm_s    = {M{1'b0}};
            inexact_s = 1'b1;
        end else if (exr_s <= EX_ZERO) begin
            unf_s     = 1'b1;
            oute_s    = {E{1'b0}};
            outm_s    = {M{1'b0}};
            inexact_s = 1'b1;
        end else begin
            oute_s    = exr_s[E-1:0];
            outm_s    = fsum_s[M-1:0];
            inexact_s = g_s | st_s;
        end
    end

    // Stage 2 result register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            outs    <= 1'b0;
            oute    <= {E{1'b0}};
            outm    <= {M{1'b0}};
            ovf     <= 1'b0;
            unf     <= 1'b0;
            inexact <= 1'b0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                outs    <= s1_r;
                oute    <= oute_s;
                outm    <= outm_s;
                ovf     <= ovf_s;
                unf     <= unf_s;
                inexact <= inexact_s;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_normal_pipe.sv
// Bench for float_mul_normal_pipe (E=8, M=23): directed vectors, backpressure,
// reset flush and a random valid/ready run against an integer reference model.
module tb_float_mul_normal_pipe;

    logic        clk, rst_n, in_valid, in_ready, ins;
    logic [9:0]  ine;
    logic [47:0] inm;
    logic        out_valid, out_ready, outs, ovf, unf, inexact;
    logic [7:0]  oute;
    logic [22:0] outm;

    int checks   = 0;
    int failures = 0;
    int acc_count = 0;
    int out_count = 0;
    logic [34:0] sb[$];
    logic [34:0] held;
    bit          held_v = 1'b0;

    float_mul_normal_pipe #(.E(8), .M(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .ine(ine), .inm(inm), .out_valid(out_valid), .out_ready(out_ready),
        .outs(outs), .oute(oute), .outm(outm), .ovf(ovf), .unf(unf), .inexact(inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: locate the MSB, keep 24 significant bits, round by remainder vs half.
    function automatic logic [34:0] model(input logic s, input logic [9:0] e, input logic [47:0] m);
        int p, ev, ex, d;
        longint unsigned x, keep, rem, half;
        logic [7:0] ex8;
        bit inx;
        p = -1;
        for (int i = 47; i >= 0; i--) if (m[i] && p < 0) p = i;
        if (p < 0) return {s, 34'd0};
        ev = $signed(e);
        ex = ev + p - 46;
        x  = 64'(m);
        d  = p - 23;
        rem = 0; half = 0;
        if (d > 0) begin
            keep = x >> d;
            rem  = x & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
        end else begin
            keep = x << (-d);
        end
        if (keep == (64'd1 << 24)) begin
            keep = 64'd1 << 23;
            ex   = ex + 1;
        end
        inx = (rem != 0);
        if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (ex <= 0)   return {s, 8'h00, 23'd0, 3'b011};
        ex8 = ex[7:0];
        return {s, ex8, keep[22:0], 2'b00, inx};
    endfunction

    // Scoreboard: push on accept, pop/compare on emit, check stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(ins, ine, inm));
                acc_count++;
            end
            if (out_valid) begin
                if (held_v) begin
                    checks++;
                    assert ({outs, oute, outm, ovf, unf, inexact} === held) else begin
                        failures++;
                        $error("FAIL hold got=%h exp=%h", {outs, oute, outm, ovf, unf, inexact}, held);
                    end
                end
                if (out_ready) begin
                    out_count++;
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL sb_extra got=%h exp=none", {outs, oute, outm, ovf, unf, inexact});
                    end
                    if (sb.size() != 0) begin
                        held = sb.pop_front();
                        checks++;
                        assert ({outs, oute, outm, ovf, unf, inexact} === held) else begin
                            failures++;
                            $error("FAIL sb_data got=%h exp=%h", {outs, oute, outm, ovf, unf, inexact}, held);
                        end
                    end
                    held_v = 1'b0;
                end else begin
                    held   = {outs, oute, outm, ovf, unf, inexact};
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One beat into an empty pipeline with out_ready high; result due two cycles later.
    task automatic directed(input string tag, input logic s, input logic [9:0] e,
                            input logic [47:0] m, input logic [34:0] exp);
        @(posedge clk); #1;
        ins = s; ine = e; inm = m; in_valid = 1'b1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk(tag, 64'({outs, oute, outm, ovf, unf, inexact}), 64'(exp));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic rand_beat();
        logic [63:0] t;
        ins = 1'($urandom);
        case ($urandom % 4)
            0: ine = 10'($urandom_range(0, 300));
            1: ine = 10'($urandom_range(240, 270));
            2: ine = 10'($urandom);
            default: ine = 10'($urandom_range(0, 60));
        endcase
        t = {$urandom, $urandom};
        case ($urandom % 8)
            0: inm = 48'd0;
            1: inm = (48'd1 << 46) | (48'd1 << 22) | (48'($urandom % 2) << 23);
            2: inm = (48'd1 << 47) | 48'($urandom % 2);
            default: begin
                t = t >> (16 + $urandom_range(0, 47));
                inm = t[47:0];
            end
        endcase
    endtask

    initial begin
        int a0, o0, sent, cyc;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ins = 1'b0; ine = 10'd0; inm = 48'd0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_fields", 64'({outs, oute, outm, ovf, unf, inexact}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        directed("one",       1'b0, 10'h07F, 48'd1 << 46, {1'b0, 8'h7F, 23'h000000, 3'b000});
        directed("one_neg",   1'b1, 10'h07F, 48'd1 << 46, {1'b1, 8'h7F, 23'h000000, 3'b000});
        directed("three",     1'b0, 10'h07F, 48'd3 << 46, {1'b0, 8'h80, 23'h400000, 3'b000});
        directed("tie_even",  1'b0, 10'h07F, (48'd1 << 46) | (48'd1 << 22), {1'b0, 8'h7F, 23'h000000, 3'b001});
        directed("tie_odd",   1'b0, 10'h07F, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22),
                 {1'b0, 8'h7F, 23'h000002, 3'b001});
        directed("rnd_carry", 1'b0, 10'h07F, (48'd1 << 47) - 48'd1, {1'b0, 8'h80, 23'h000000, 3'b001});
        directed("overflow",  1'b0, 10'h0FE, 48'd1 << 47, {1'b0, 8'hFF, 23'h000000, 3'b101});
        directed("underflow", 1'b0, 10'h000, 48'd1 << 46, {1'b0, 8'h00, 23'h000000, 3'b011});
        directed("zero",      1'b0, 10'h000, 48'd0, 35'd0);
        directed("lz_shift",  1'b0, 10'h085, 48'd1 << 40, {1'b0, 8'h7F, 23'h000000, 3'b000});
        drain("directed");

        // Backpressure: three beats offered while the consumer stalls.
        a0 = acc_count; o0 = out_count;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; ins = 1'b0; ine = 10'h07F; inm = 48'd1 << 46;
        @(posedge clk); #1;
        ine = 10'h080; inm = 48'd3 << 45;
        @(posedge clk); #1;
        ine = 10'h081; inm = (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22);
        chk("bp_in_ready0", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_in_ready1", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(acc_count - a0), 64'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("bp");
        chk("bp_outputs", 64'(out_count - o0), 64'd3);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; ine = 10'h07F; inm = 48'd1 << 46;
        @(posedge clk); #1;
        inm = 48'd3 << 46;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        o0 = out_count;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_stale", 64'(out_count - o0), 64'd0);
        directed("post_rst", 1'b1, 10'h07F, (48'd1 << 47) - 48'd1, {1'b1, 8'h80, 23'h000000, 3'b001});
        drain("post_rst");

        // Random valid/ready traffic against the reference model.
        sent = 0; cyc = 0;
        @(posedge clk); #1;
        while (sent < 10000 && cyc < 80000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && ($urandom % 4) != 0 && sent < 10000) begin
                rand_beat();
                in_valid = 1'b1;
            end
            out_ready = ($urandom % 4) != 0;
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
